// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial add/subtract unit: operation
// encodings, FSM state encoding and the carry-seeding helpers.
package serial_addsub_pkg;

    localparam int unsigned OP_W = 2;
    localparam int unsigned ST_W = 2;

    localparam logic [OP_W-1:0] OP_ADD = 2'b00;
    localparam logic [OP_W-1:0] OP_SUB = 2'b01;
    localparam logic [OP_W-1:0] OP_ADC = 2'b10;
    localparam logic [OP_W-1:0] OP_SBB = 2'b11;

    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_RUN  = 2'd1;
    localparam logic [ST_W-1:0] ST_DONE = 2'd2;

    // Subtracting ops add the one's complement of b.
    function automatic logic op_is_sub(input logic [OP_W-1:0] op);
        return (op == OP_SUB) || (op == OP_SBB);
    endfunction

    // Carry fed into bit 0: SUB adds the +1 of two's complement,
    // SBB treats cin as a borrow so the incoming carry is its inverse.
    function automatic logic init_carry(input logic [OP_W-1:0] op, input logic cin);
        logic c;
        case (op)
            OP_ADD:  c = 1'b0;
            OP_SUB:  c = 1'b1;
            OP_ADC:  c = cin;
            default: c = ~cin;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/serial_addsub_fa_bit.sv
// One-bit full adder cell used by the serial datapath.
// Ports: a, b, cin -> s (sum), cout (carry out).
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one bit per clock, LSB first, through a
// single full-adder cell. W+2 cycles per operation (accept, W bits, done).
// Ports: clk, rst_n (async active-low), start/op/cin/a/b request inputs;
// busy, done (1-cycle pulse), result, cout, ovf registered outputs.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic         cin,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         ovf
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    logic [ST_W-1:0] state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    a_sh_q, a_sh_d;
    logic [W-1:0]    b_sh_q, b_sh_d;
    logic [W-1:0]    r_sh_q, r_sh_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    result_q, result_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            fa_s;
    logic            fa_co;

    // Single shared bit cell.
    fa_bit u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_co)
    );

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        r_sh_d   = r_sh_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        // done trails the DONE state by one edge.
        done_d   = (state_q == ST_DONE);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = op_is_sub(op) ? ~b : b;
                    carry_d = init_carry(op, cin);
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                // Sum bits enter at the MSB so bit 0 lands at position 0 after W shifts.
                r_sh_d  = (r_sh_q >> 1) | (W'(fa_s) << (W - 1));
                carry_d = fa_co;
                if (cnt_q == CW'(W - 1)) begin
                    state_d  = ST_DONE;
                    result_d = r_sh_d;
                    cout_d   = fa_co;
                    // carry_q is the carry into the MSB on this last bit.
                    ovf_d    = carry_q ^ fa_co;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            r_sh_q   <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            r_sh_q   <= r_sh_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub at W=8, W=2 and W=32.
module tb_serial_addsub;

    typedef struct {
        logic [31:0] r;
        logic        c;
        logic        v;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic        cin;
    logic [31:0] a;
    logic [31:0] b;
    int          sel;
    int          cyc;

    int n_cmp;
    int n_bad;

    exp_t q8[$];
    exp_t q2[$];
    exp_t q32[$];

    logic        st8, st2, st32;
    logic        busy8, done8, co8, ov8;
    logic        busy2, done2, co2, ov2;
    logic        busy32, done32, co32, ov32;
    logic [7:0]  res8;
    logic [1:0]  res2;
    logic [31:0] res32;

    assign st8  = start && (sel == 0);
    assign st2  = start && (sel == 1);
    assign st32 = start && (sel == 2);

    serial_addsub #(.W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .op(op), .cin(cin),
        .a(a[7:0]), .b(b[7:0]), .busy(busy8), .done(done8),
        .result(res8), .cout(co8), .ovf(ov8)
    );

    serial_addsub #(.W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(st2), .op(op), .cin(cin),
        .a(a[1:0]), .b(b[1:0]), .busy(busy2), .done(done2),
        .result(res2), .cout(co2), .ovf(ov2)
    );

    serial_addsub #(.W(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(st32), .op(op), .cin(cin),
        .a(a), .b(b), .busy(busy32), .done(done32),
        .result(res32), .cout(co32), .ovf(ov32)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: pop the oldest expectation for the DUT that pulsed done.
    task automatic chk(input int s, input logic [31:0] r, input logic c, input logic v);
        exp_t e;
        bit   have;
        have = 1'b0;
        case (s)
            0: if (q8.size()  > 0) begin e = q8.pop_front();  have = 1'b1; end
            1: if (q2.size()  > 0) begin e = q2.pop_front();  have = 1'b1; end
            default: if (q32.size() > 0) begin e = q32.pop_front(); have = 1'b1; end
        endcase
        n_cmp++;
        if (!have) begin
            n_bad++;
            $display("FAIL unexpected_done dut%0d: got result %h with empty queue, required no done", s, r);
        end else begin
            cmp($sformatf("result dut%0d", s), r, e.r);
            cmp($sformatf("cout dut%0d", s), 32'(c), 32'(e.c));
            cmp($sformatf("ovf dut%0d", s), 32'(v), 32'(e.v));
            cmp($sformatf("done_cycle dut%0d", s), 32'(cyc), 32'(e.cyc));
        end
    endtask

    always @(negedge clk) begin
        if (done8)  chk(0, 32'(res8), co8, ov8);
        if (done2)  chk(1, 32'(res2), co2, ov2);
        if (done32) chk(2, res32, co32, ov32);
    end

    // Issue one op on DUT s at a negedge, then spend W+2 cycles with
    // operand inputs scrambled. hold keeps start high throughout (ignored
    // while busy); pulse raises start for one cycle at that loop index.
    task automatic issue(input int s, input logic [1:0] o, input logic [31:0] av,
                         input logic [31:0] bv, input logic ci, input logic [31:0] er,
                         input logic ec, input logic ev, input bit hold, input int pulse);
        int   w;
        exp_t e;
        w = (s == 0) ? 8 : (s == 1) ? 2 : 32;
        sel   = s;
        op    = o;
        a     = av;
        b     = bv;
        cin   = ci;
        start = 1'b1;
        e.r   = er;
        e.c   = ec;
        e.v   = ev;
        e.cyc = cyc + w + 2;
        case (s)
            0: q8.push_back(e);
            1: q2.push_back(e);
            default: q32.push_back(e);
        endcase
        for (int i = 0; i < w + 2; i++) begin
            @(negedge clk);
            a     = $urandom;
            b     = $urandom;
            op    = 2'($urandom);
            cin   = 1'($urandom);
            start = hold || (i == pulse);
        end
        start = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        sel   = 0;
        start = 1'b0;
        op    = 2'b00;
        cin   = 1'b0;
        a     = '0;
        b     = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        cmp("reset_result", 32'(res8), 32'h0);
        cmp("reset_busy", 32'(busy8), 32'h0);
        cmp("reset_done", 32'(done8), 32'h0);
        cmp("reset_cout_ovf", 32'({co8, ov8}), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed W=8 vectors.
        issue(0, 2'b00, 32'h7F, 32'h01, 1'b0, 32'h80, 1'b0, 1'b1, 1'b0, -1);
        issue(0, 2'b01, 32'h05, 32'h07, 1'b0, 32'hFE, 1'b0, 1'b0, 1'b0, -1);
        issue(0, 2'b01, 32'h07, 32'h05, 1'b0, 32'h02, 1'b1, 1'b0, 1'b0, -1);
        issue(0, 2'b10, 32'hFF, 32'h00, 1'b1, 32'h00, 1'b1, 1'b0, 1'b0, -1);
        issue(0, 2'b11, 32'h00, 32'h00, 1'b1, 32'hFF, 1'b0, 1'b0, 1'b0, -1);
        // Start re-pulsed 3 cycles in with other operands: must be ignored.
        issue(0, 2'b00, 32'h10, 32'h20, 1'b0, 32'h30, 1'b0, 1'b0, 1'b0, 2);

        // Abort at bit 4 with reset; no done may appear for this op.
        sel   = 0;
        op    = 2'b00;
        a     = 32'h12;
        b     = 32'h34;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        cmp("result_held_mid_op", 32'(res8), 32'h30);
        cmp("busy_mid_op", 32'(busy8), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        cmp("abort_result", 32'(res8), 32'h0);
        cmp("abort_busy", 32'(busy8), 32'h0);
        cmp("abort_done", 32'(done8), 32'h0);
        cmp("abort_cout_ovf", 32'({co8, ov8}), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(0, 2'b00, 32'h03, 32'h04, 1'b0, 32'h07, 1'b0, 1'b0, 1'b0, -1);

        // start held high: back-to-back ops every W+2 cycles.
        issue(0, 2'b00, 32'h3C, 32'h4A, 1'b0, 32'h86, 1'b0, 1'b1, 1'b1, -1);
        issue(0, 2'b01, 32'h80, 32'h01, 1'b0, 32'h7F, 1'b1, 1'b1, 1'b1, -1);
        issue(0, 2'b10, 32'hC8, 32'h64, 1'b1, 32'h2D, 1'b1, 1'b0, 1'b1, -1);
        issue(0, 2'b11, 32'h50, 32'h30, 1'b1, 32'h1F, 1'b1, 1'b0, 1'b1, -1);

        // W=2 regression.
        issue(1, 2'b00, 32'h1, 32'h1, 1'b0, 32'h2, 1'b0, 1'b1, 1'b1, -1);
        issue(1, 2'b01, 32'h0, 32'h1, 1'b0, 32'h3, 1'b0, 1'b0, 1'b1, -1);
        issue(1, 2'b11, 32'h2, 32'h1, 1'b0, 32'h1, 1'b1, 1'b1, 1'b1, -1);
        issue(1, 2'b10, 32'h3, 32'h3, 1'b1, 32'h3, 1'b1, 1'b0, 1'b0, -1);

        // W=32 regression.
        issue(2, 2'b00, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b1, -1);
        issue(2, 2'b01, 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, -1);
        issue(2, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, -1);
        issue(2, 2'b11, 32'h12345678, 32'h02345678, 1'b1, 32'h0FFFFFFF, 1'b1, 1'b0, 1'b0, -1);

        repeat (5) @(negedge clk);
        cmp("pending_dut8", 32'(q8.size()), 32'h0);
        cmp("pending_dut2", 32'(q2.size()), 32'h0);
        cmp("pending_dut32", 32'(q32.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
